// File: rtl/hi_lo_muldiv_ctrl.sv
// rtl/hi_lo_muldiv_ctrl.sv - iterative multiply/divide sequencer owning all HI/LO register writes
module hi_lo_muldiv_ctrl #(
    parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    input  logic        read_req,
    output logic        stall,
    output logic        busy,
    output logic [31:0] HI_input,
    output logic [31:0] LO_input,
    output logic        HI_write_enable,
    output logic        LO_write_enable
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] acc, acc_nx;
    logic [31:0] opnd, raw_a, hi_q, lo_q;
    logic [4:0]  count;
    logic        is_div, neg_q, neg_r, div0;

    logic        accept, is_signed, is_arith;
    logic [31:0] mag_a, mag_b;
    logic [32:0] sum33, rem_t, rem_diff;
    logic [63:0] prod_res;
    logic [31:0] res_hi, res_lo;

    assign op_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign stall     = (op_valid & ~op_ready) | (read_req & busy);
    assign accept    = op_valid & op_ready & clk_enable;
    assign is_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
    assign is_arith  = (op_code[2] == 1'b0);
    assign mag_a     = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
    assign mag_b     = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;

    // Multiply keeps the multiplier in acc[31:0] and shifts the product in from the top;
    // divide keeps the partial remainder in acc[63:32] and shifts quotient bits into acc[31:0].
    always_comb begin
        sum33    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
        rem_t    = {acc[63:32], acc[31]};
        rem_diff = rem_t - {1'b0, opnd};
        acc_nx   = {sum33, acc[31:1]};
        if (is_div) begin
            if (!rem_diff[32]) acc_nx = {rem_diff[31:0], acc[30:0], 1'b1};
            else               acc_nx = {rem_t[31:0], acc[30:0], 1'b0};
        end
    end

    always_comb begin
        prod_res = neg_q ? (~acc + 64'd1) : acc;
        res_hi   = prod_res[63:32];
        res_lo   = prod_res[31:0];
        if (is_div) begin
            if (div0) begin
                res_hi = raw_a;
                res_lo = DIV0_LO;
            end else begin
                res_hi = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
                res_lo = neg_q ? (~acc[31:0] + 32'd1) : acc[31:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && is_arith) state_nx = CALC;
            CALC:    if (count == 5'd31) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        HI_input        = hi_q;
        LO_input        = lo_q;
        HI_write_enable = 1'b0;
        LO_write_enable = 1'b0;
        if (state == IDLE && accept && op_code == OP_MTHI) begin
            HI_input        = op_a;
            HI_write_enable = ~reset;
        end
        if (state == IDLE && accept && op_code == OP_MTLO) begin
            LO_input        = op_a;
            LO_write_enable = ~reset;
        end
        if (state == DONE && clk_enable) begin
            HI_input        = res_hi;
            LO_input        = res_lo;
            HI_write_enable = ~reset;
            LO_write_enable = ~reset;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= 64'd0;
            opnd   <= 32'd0;
            raw_a  <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            count  <= 5'd0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
        end else if (clk_enable) begin
            state <= state_nx;
            if (HI_write_enable) hi_q <= HI_input;
            if (LO_write_enable) lo_q <= LO_input;
            if (state == IDLE && accept && is_arith) begin
                is_div <= op_code[1];
                opnd   <= op_code[1] ? mag_b : mag_a;
                acc    <= {32'd0, op_code[1] ? mag_a : mag_b};
                raw_a  <= op_a;
                count  <= 5'd0;
                neg_q  <= is_signed & (op_a[31] ^ op_b[31]);
                neg_r  <= is_signed & op_a[31];
                div0   <= op_code[1] & (op_b == 32'd0);
            end else if (state == CALC) begin
                acc   <= acc_nx;
                count <= count + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_hi_lo_muldiv_ctrl.sv
// tb/tb_hi_lo_muldiv_ctrl.sv - scoreboard bench for hi_lo_muldiv_ctrl
module tb_hi_lo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset, clk_enable, op_valid, read_req;
    logic [2:0]  op_code;
    logic [31:0] op_a, op_b;
    logic        op_ready, stall, busy, HI_write_enable, LO_write_enable;
    logic [31:0] HI_input, LO_input;

    hi_lo_muldiv_ctrl dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .op_valid(op_valid), .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready), .read_req(read_req), .stall(stall), .busy(busy),
        .HI_input(HI_input), .LO_input(LO_input),
        .HI_write_enable(HI_write_enable), .LO_write_enable(LO_write_enable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          hw;
        bit          lw;
        logic [31:0] hi;
        logic [31:0] lo;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (HI_write_enable === 1'b1 || LO_write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write at cycle %0d: hi_we=%b lo_we=%b expected no write",
                         cyc, HI_write_enable, LO_write_enable);
            end else begin
                e = sb.pop_front();
                check_bit("hi_we", HI_write_enable, e.hw);
                check_bit("lo_we", LO_write_enable, e.lw);
                check("write_cycle", 32'(cyc), 32'(e.at));
                if (e.hw) check("hi_data", HI_input, e.hi);
                if (e.lw) check("lo_data", LO_input, e.lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit hw, input bit lw, input logic [31:0] hi, input logic [31:0] lo,
                        input int at);
        exp_t e;
        e.hw = hw; e.lw = lw; e.hi = hi; e.lo = lo; e.at = at;
        sb.push_back(e);
    endtask

    // Presents a request for one cycle; acc_cyc is the edge count at which it is taken.
    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                         output int acc_cyc);
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        tick();
        acc_cyc  = cyc;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (op_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_bit("idle_timeout", op_ready, 1'b1);
    endtask

    task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo);
        int e;
        push(1'b1, 1'b1, hi, lo, cyc + 33);
        issue(code, a, b, e);
        wait_idle();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        reset = 1'b1; clk_enable = 1'b1; op_valid = 1'b0; read_req = 1'b0;
        op_code = 3'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_bit("reset_op_ready", op_ready, 1'b1);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_stall", stall, 1'b0);
        check("reset_hi", HI_input, 32'h0);
        check("reset_lo", LO_input, 32'h0);
        tick();

        // MTHI with a simultaneous MFHI-style read: zero latency, never stalls
        op_valid = 1'b1; op_code = 3'd4; op_a = 32'h1234_5678; read_req = 1'b1;
        push(1'b1, 1'b0, 32'h1234_5678, 32'h0, cyc);
        @(negedge clk);
        check_bit("mthi_stall", stall, 1'b0);
        check_bit("mthi_busy", busy, 1'b0);
        tick();
        read_req = 1'b0;
        op_code = 3'd5; op_a = 32'hCAFE_BABE;
        push(1'b0, 1'b1, 32'h0, 32'hCAFE_BABE, cyc);
        tick();
        op_valid = 1'b0;
        @(negedge clk);
        check("hold_hi", HI_input, 32'h1234_5678);
        check("hold_lo", LO_input, 32'hCAFE_BABE);
        tick();

        // Reserved op is consumed with no effect
        issue(3'd6, 32'h1, 32'h2, e);
        @(negedge clk);
        check_bit("reserved_idle", op_ready, 1'b1);
        tick();

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op(3'd3, 32'd7,         32'd0,          32'h0000_0007, 32'hFFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000);
        run_op(3'd2, 32'd100,       32'hFFFF_FFF9,  32'h0000_0002, 32'hFFFF_FFF2);
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op(3'd3, 32'd100,       32'd7,          32'h0000_0002, 32'h0000_000E);

        // Read and a new request while busy: stall through DONE, request not taken
        push(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFF0_BDC0, cyc + 33);
        issue(3'd0, 32'd1000, 32'hFFFF_FC18, e);
        repeat (3) tick();
        read_req = 1'b1; op_valid = 1'b1; op_code = 3'd4; op_a = 32'hDEAD_BEEF;
        @(negedge clk);
        check_bit("busy_op_ready", op_ready, 1'b0);
        check_bit("busy_req_stall", stall, 1'b1);
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check_bit("read_stall", stall, (cyc <= e + 32));
            tick();
        end
        read_req = 1'b0;
        wait_idle();
        tick();

        // Reset mid-CALC aborts without any write
        issue(3'd1, 32'd5, 32'd6, e);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_bit("abort_op_ready", op_ready, 1'b1);
        check_bit("abort_busy", busy, 1'b0);
        repeat (40) tick();

        // Freeze for 8 cycles mid-CALC delays the result by exactly 8
        push(1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000, cyc + 33 + 8);
        issue(3'd1, 32'h0001_0000, 32'h0001_0000, e);
        repeat (5) tick();
        clk_enable = 1'b0;
        repeat (8) tick();
        check_bit("freeze_busy", busy, 1'b1);
        clk_enable = 1'b1;
        wait_idle();
        repeat (3) tick();

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
